// File: rtl/i2s_rx_deserializer_pkg.sv
// Shared types and helpers for the I2S receive deserializer.
// The optional peak meter (I2S_RX_PEAK_EN) uses abs_sat below.
package i2s_pkg;

    typedef enum logic [1:0] {
        ALIGN,
        SHIFT,
        PAD
    } rx_state_t;

    localparam int I2S_DEFAULT_SAMPLE_W = 16;

    // Magnitude of a w-bit two's complement value.
    // The most negative code saturates to the largest positive one.
    function automatic logic [31:0] abs_sat(
        input logic signed [31:0] v,
        input int unsigned        w
    );
        logic signed [31:0] most_neg;
        most_neg = -(32'sd1 <<< (w - 1));
        if (v == most_neg)
            return (32'd1 << (w - 1)) - 32'd1;
        if (v < 0)
            return $unsigned(-v);
        return $unsigned(v);
    endfunction

endpackage

// File: rtl/i2s_rx_deserializer_if.sv
// Stereo sample handshake between the I2S receiver and its consumer.
// master = receiver side, slave = consumer side.
interface i2s_rx_deserializer_if #(
    parameter int SAMPLE_W = i2s_pkg::I2S_DEFAULT_SAMPLE_W
);
    logic [SAMPLE_W-1:0] sample_l;
    logic [SAMPLE_W-1:0] sample_r;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output sample_l,
        output sample_r,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_rx_deserializer_edge_sync.sv
// Synchronizes the codec pins into the Clk domain and
// produces a one-Clk strobe on each synchronized sclk rise.
module i2s_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i2s_sclk,
    input  logic i2s_lrclk,
    input  logic i2s_din,
    output logic sclk_rise,
    output logic lrclk_s,
    output logic din_s
);
    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] lrclk_ff;
    logic [SYNC_STAGES-1:0] din_ff;
    logic                   sclk_prev;

    // Equal-depth chains keep lrclk/din aligned with the sclk strobe
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sclk_ff   <= '0;
            lrclk_ff  <= '0;
            din_ff    <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], i2s_sclk};
            lrclk_ff  <= {lrclk_ff[SYNC_STAGES-2:0], i2s_lrclk};
            din_ff    <= {din_ff[SYNC_STAGES-2:0], i2s_din};
            sclk_prev <= sclk_ff[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_ff[SYNC_STAGES-1] & ~sclk_prev;
    assign lrclk_s   = lrclk_ff[SYNC_STAGES-1];
    assign din_s     = din_ff[SYNC_STAGES-1];
endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S ADC receiver: deserializes L/R slots into stereo pairs on a handshake.
// Define I2S_RX_PEAK_EN to add the peak_level magnitude meter.
module i2s_rx_deserializer import i2s_pkg::*; #(
    parameter int SAMPLE_W    = I2S_DEFAULT_SAMPLE_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  i2s_sclk,
    input  logic                  i2s_lrclk,
    input  logic                  i2s_din,
    i2s_rx_deserializer_if.master smp,
    output logic                  overrun,
    input  logic                  clear_overrun
`ifdef I2S_RX_PEAK_EN
    ,
    output logic [SAMPLE_W-1:0]   peak_level
`endif
);
    localparam int CNT_W = $clog2(SAMPLE_W + 1);
    localparam logic [SAMPLE_W-1:0] MSB_ONE = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic                sclk_rise;
    logic                lrclk_s;
    logic                din_s;
    logic                lr_prev;
    logic                boundary;
    rx_state_t           state_q;
    rx_state_t           state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [SAMPLE_W-1:0] slot_q;
    logic [SAMPLE_W-1:0] slot_word;
    logic [SAMPLE_W-1:0] left_q;
    logic                slot_open;
    logic                slot_close;
    logic                shift_en;
    logic                commit;
    logic                accept;

    i2s_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .Clk       (Clk),
        .Reset     (Reset),
        .i2s_sclk  (i2s_sclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_din   (i2s_din),
        .sclk_rise (sclk_rise),
        .lrclk_s   (lrclk_s),
        .din_s     (din_s)
    );

    assign boundary = sclk_rise && (lrclk_s != lr_prev);

    // Bits land left-aligned, so a short slot is already zero-filled
    assign slot_word = (state_q == SHIFT && din_s)
                     ? (slot_q | (MSB_ONE >> cnt_q)) : slot_q;

    assign commit = slot_close && lr_prev;
    assign accept = smp.sample_valid && smp.sample_ready;

    // FSM state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state_q <= ALIGN;
        else
            state_q <= state_d;
    end

    // FSM next state, advanced only on the sclk strobe
    always_comb begin
        state_d = state_q;
        if (sclk_rise) begin
            unique case (state_q)
                ALIGN: if (boundary && !lrclk_s) state_d = SHIFT;
                SHIFT: begin
                    if (boundary)
                        state_d = SHIFT;
                    else if (cnt_q == CNT_W'(SAMPLE_W - 1))
                        state_d = PAD;
                end
                PAD:   if (boundary) state_d = SHIFT;
                default: state_d = ALIGN;
            endcase
        end
    end

    // FSM output decode
    always_comb begin
        slot_open  = 1'b0;
        slot_close = 1'b0;
        shift_en   = 1'b0;
        if (sclk_rise) begin
            unique case (state_q)
                ALIGN: slot_open = boundary && !lrclk_s;
                SHIFT: begin
                    shift_en   = 1'b1;
                    slot_close = boundary;
                end
                PAD:   slot_close = boundary;
                default: ;
            endcase
        end
    end

    // Slot register, saturating bit count and previous lrclk
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            slot_q  <= '0;
            cnt_q   <= '0;
            lr_prev <= 1'b0;
        end else begin
            if (sclk_rise)
                lr_prev <= lrclk_s;
            if (slot_open || slot_close) begin
                slot_q <= '0;
                cnt_q  <= '0;
            end else if (shift_en && cnt_q != CNT_W'(SAMPLE_W)) begin
                slot_q <= slot_word;
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

    // Closed left slot waits here for its right partner
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            left_q <= '0;
        else if (slot_close && !lr_prev)
            left_q <= slot_word;
    end

    // Output pair: a simultaneous accept frees room for the new pair
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            smp.sample_l     <= '0;
            smp.sample_r     <= '0;
            smp.sample_valid <= 1'b0;
        end else if (commit && (!smp.sample_valid || smp.sample_ready)) begin
            smp.sample_l     <= left_q;
            smp.sample_r     <= slot_word;
            smp.sample_valid <= 1'b1;
        end else if (accept) begin
            smp.sample_valid <= 1'b0;
        end
    end

    // Sticky overrun; a new drop beats a same-cycle clear
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            overrun <= 1'b0;
        else if (commit && smp.sample_valid && !smp.sample_ready)
            overrun <= 1'b1;
        else if (clear_overrun)
            overrun <= 1'b0;
    end

`ifdef I2S_RX_PEAK_EN
    logic [SAMPLE_W-1:0] mag_l;
    logic [SAMPLE_W-1:0] mag_r;
    logic [SAMPLE_W-1:0] peak_d;

    // Peak over every committed pair, dropped ones included
    always_comb begin
        mag_l  = SAMPLE_W'(abs_sat(32'(signed'(left_q)), SAMPLE_W));
        mag_r  = SAMPLE_W'(abs_sat(32'(signed'(slot_word)), SAMPLE_W));
        peak_d = (accept && clear_overrun) ? '0 : peak_level;
        if (commit) begin
            if (mag_l > peak_d) peak_d = mag_l;
            if (mag_r > peak_d) peak_d = mag_r;
        end
    end

    // Peak register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            peak_level <= '0;
        else
            peak_level <= peak_d;
    end
`endif

endmodule
